rs_queue: RTL and testbench

Parametrised multi-entry reservation station between dispatch and one execution unit. Holds up to `DEPTH` dispatched instructions and snoops all CDB ports to wake renamed source operands. Each cycle it presents the oldest instruction whose four sources are all resolved. Oldest-first issue uses an age-ordered collapsing queue.

---
 rtl/rs_queue_pkg.sv | 43 ++++
 rtl/rs_queue_wakeup.sv | 20 ++
 rtl/rs_queue.sv | 86 ++++++++
 tb/tb_rs_queue.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/rs_queue_pkg.sv
// rs_queue_pkg: shared instruction, operand and CDB packet types for the reservation station.
package rs_queue_pkg;
  localparam int PIPE_WIDTH = 2;
  localparam int TAG_W = 6;
  localparam int DATA_W = 32;
  localparam int PC_W = 32;

  typedef struct packed {
    logic              is_renamed;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } operand_t;

  typedef struct packed {
    logic              is_valid;
    logic [PC_W-1:0]   pc;
    logic [TAG_W-1:0]  dest_tag;
    operand_t          src_0_a;
    operand_t          src_0_b;
    operand_t          src_1_a;
    operand_t          src_1_b;
  } instruction_t;

  typedef struct packed {
    logic              is_valid;
    logic [TAG_W-1:0]  dest_tag;
    logic [DATA_W-1:0] result;
  } writeback_packet_t;

  function automatic operand_t get_op(instruction_t ins, int k);
    return k == 0 ? ins.src_0_a : k == 1 ? ins.src_0_b : k == 2 ? ins.src_1_a : ins.src_1_b;
  endfunction

  function automatic instruction_t set_op(instruction_t ins, int k, operand_t op);
    instruction_t r;
    r = ins;
    if (k == 0) r.src_0_a = op;
    else if (k == 1) r.src_0_b = op;
    else if (k == 2) r.src_1_a = op;
    else r.src_1_b = op;
    return r;
  endfunction
endpackage

// File: rtl/rs_queue_wakeup.sv
// rs_wakeup: per-operand CDB snoop; lowest matching port supplies the captured result.
module rs_wakeup import rs_queue_pkg::*; #(
  parameter int NUM_CDB = PIPE_WIDTH
) (
  input  operand_t                         i_op,
  input  writeback_packet_t [NUM_CDB-1:0]  i_cdb,
  output operand_t                         o_op,
  output logic                             o_hit
);
  always_comb begin
    o_op = i_op;
    o_hit = 1'b0;
    for (int i = NUM_CDB - 1; i >= 0; i--)
      if (i_op.is_renamed && i_cdb[i].is_valid && i_cdb[i].dest_tag == i_op.tag) begin
        o_op.data = i_cdb[i].result;
        o_op.is_renamed = 1'b0;
        o_hit = 1'b1;
      end
  end
endmodule

// File: rtl/rs_queue.sv
// rs_queue: age-ordered collapsing reservation station with CDB wakeup and oldest-ready issue.
module rs_queue import rs_queue_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int NUM_CDB = PIPE_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            cache_stall,
  input  instruction_t                    rs_entry,
  input  logic                            rs_we,
  output logic                            rs_write_rdy,
  output logic                            rs_read_rdy,
  output instruction_t                    execute_pkt,
  input  logic                            alu_re,
  input  writeback_packet_t [NUM_CDB-1:0] cdb_ports,
  output logic [$clog2(DEPTH+1)-1:0]      occupancy
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(DEPTH);
  instruction_t r_slots [DEPTH];
  logic [CW-1:0] r_count;
  instruction_t w_raw [DEPTH+1];
  instruction_t w_upd [DEPTH+1];
  instruction_t w_next [DEPTH];
  operand_t w_op [DEPTH+1][4];
  logic w_hit [DEPTH+1][4];
  logic [DEPTH-1:0] w_rdy;
  logic [SW-1:0] w_sel;
  logic w_issue, w_alloc;
  logic [CW-1:0] w_tail, w_cnt_nxt;
  // Index DEPTH is the incoming dispatch entry, woken alongside the stored slots.
  for (genvar g = 0; g < DEPTH; g++) begin : g_raw
    assign w_raw[g] = r_slots[g];
    assign w_rdy[g] = CW'(g) < r_count && !r_slots[g].src_0_a.is_renamed && !r_slots[g].src_0_b.is_renamed
                      && !r_slots[g].src_1_a.is_renamed && !r_slots[g].src_1_b.is_renamed;
  end
  assign w_raw[DEPTH] = rs_entry;
  for (genvar g = 0; g <= DEPTH; g++) begin : g_wk
    for (genvar k = 0; k < 4; k++) begin : g_op
      rs_wakeup #(.NUM_CDB(NUM_CDB)) u_wk (
        .i_op  (get_op(w_raw[g], k)),
        .i_cdb (cdb_ports),
        .o_op  (w_op[g][k]),
        .o_hit (w_hit[g][k])
      );
    end
  end
  always_comb begin
    for (int g = 0; g <= DEPTH; g++) begin
      w_upd[g] = w_raw[g];
      for (int k = 0; k < 4; k++)
        if (w_hit[g][k]) w_upd[g] = set_op(w_upd[g], k, w_op[g][k]);
    end
  end
  always_comb begin
    w_sel = '0;
    for (int s = DEPTH - 1; s >= 0; s--)
      if (w_rdy[s]) w_sel = SW'(s);
  end
  assign rs_write_rdy = r_count < CW'(DEPTH);
  assign rs_read_rdy = |w_rdy;
  assign execute_pkt = rs_read_rdy ? r_slots[w_sel] : '0;
  assign occupancy = r_count;
  assign w_issue = rs_read_rdy && alu_re;
  assign w_alloc = rs_we && rs_entry.is_valid && rs_write_rdy && !cache_stall && !flush;
  assign w_tail = r_count - CW'(w_issue);
  assign w_cnt_nxt = w_tail + CW'(w_alloc);
  // Slots at or above the issued one take their younger neighbour; the tail receives the new entry.
  always_comb begin
    for (int s = 0; s < DEPTH; s++) begin
      w_next[s] = (w_issue && SW'(s) >= w_sel) ? (s < DEPTH - 1 ? w_upd[s+1] : '0) : w_upd[s];
      if (CW'(s) >= w_cnt_nxt) w_next[s] = '0;
      if (w_alloc && CW'(s) == w_tail) w_next[s] = w_upd[DEPTH];
    end
  end
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_count <= '0;
      for (int s = 0; s < DEPTH; s++) r_slots[s] <= '0;
    end else begin
      r_count <= w_cnt_nxt;
      for (int s = 0; s < DEPTH; s++) r_slots[s] <= w_next[s];
    end
  end
endmodule

// File: tb/tb_rs_queue.sv
// tb_rs_queue: scoreboard bench; expected issue packets are queued at stimulus time and compared on issue.
module tb_rs_queue;
  import rs_queue_pkg::*;
  localparam int DEPTH = 4;
  localparam int NC = PIPE_WIDTH;
  logic clk = 1'b0;
  logic rst, flush, cache_stall, rs_we, alu_re, rs_write_rdy, rs_read_rdy;
  instruction_t rs_entry, execute_pkt;
  writeback_packet_t [NC-1:0] cdb_ports;
  logic [2:0] occupancy;
  int checks = 0;
  int errors = 0;
  instruction_t sb [$];

  rs_queue #(.DEPTH(DEPTH), .NUM_CDB(NC)) dut (
    .clk(clk), .rst(rst), .flush(flush), .cache_stall(cache_stall),
    .rs_entry(rs_entry), .rs_we(rs_we), .rs_write_rdy(rs_write_rdy),
    .rs_read_rdy(rs_read_rdy), .execute_pkt(execute_pkt), .alu_re(alu_re),
    .cdb_ports(cdb_ports), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [255:0] got, logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic instruction_t mk(logic [31:0] pc, logic [3:0] ren, logic [TAG_W-1:0] tag);
    instruction_t r;
    operand_t o;
    r = '0;
    r.is_valid = 1'b1;
    r.pc = pc;
    r.dest_tag = pc[TAG_W-1:0];
    for (int k = 0; k < 4; k++) begin
      o.is_renamed = ren[k];
      o.tag = ren[k] ? tag : '0;
      o.data = ren[k] ? '0 : pc + 32'(k) + 32'h1000;
      r = set_op(r, k, o);
    end
    return r;
  endfunction

  function automatic instruction_t wake(instruction_t r, int k, logic [31:0] d);
    operand_t o;
    o = get_op(r, k);
    o.is_renamed = 1'b0;
    o.data = d;
    return set_op(r, k, o);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(instruction_t e);
    rs_entry = e;
    rs_we = 1'b1;
    tick();
    rs_we = 1'b0;
  endtask

  always @(negedge clk)
    if (!rst && !flush && rs_read_rdy && alu_re) begin
      if (sb.size() == 0) check("sb_unexpected_issue", 1, 0);
      else check("issue_pkt", execute_pkt, sb.pop_front());
    end

  instruction_t a, b, c, d, s0, s1, q, p0, p1, p2, p3, p4, r0, r1, r2;

  initial begin
    rst = 1'b1; flush = 1'b0; cache_stall = 1'b0; rs_we = 1'b0; alu_re = 1'b0;
    rs_entry = '0; cdb_ports = '0;
    tick(); tick();
    check("rst_wr_rdy", rs_write_rdy, 1);
    check("rst_rd_rdy", rs_read_rdy, 0);
    check("rst_occ", occupancy, 0);
    check("rst_pkt", execute_pkt, 0);
    rst = 1'b0;
    a = mk(32'h100, 4'b0000, 0); b = mk(32'h104, 4'b0000, 0);
    c = mk(32'h108, 4'b0000, 0); d = mk(32'h10c, 4'b0000, 0);
    disp(a);
    check("first_rd_rdy", rs_read_rdy, 1);
    check("first_occ", occupancy, 1);
    check("first_pkt", execute_pkt, a);
    disp(b); disp(c); disp(d);
    check("full_wr_rdy", rs_write_rdy, 0);
    check("full_occ", occupancy, 4);
    disp(mk(32'h110, 4'b0000, 0));
    check("fifth_rejected_occ", occupancy, 4);
    sb.push_back(a); sb.push_back(b); sb.push_back(c); sb.push_back(d);
    alu_re = 1'b1;
    tick();
    check("drain_wr_rdy", rs_write_rdy, 1);
    check("drain_occ", occupancy, 3);
    check("drain_head", execute_pkt, b);
    tick(); tick(); tick();
    alu_re = 1'b0;
    check("drained_occ", occupancy, 0);
    check("drained_rd", rs_read_rdy, 0);
    // Blocked allocations: cache stall and an invalid entry.
    cache_stall = 1'b1;
    disp(a);
    cache_stall = 1'b0;
    check("stall_occ", occupancy, 0);
    q = a; q.is_valid = 1'b0;
    disp(q);
    check("invalid_occ", occupancy, 0);
    // Out-of-order issue: younger ready entry goes first, older woken by CDB port 1.
    s0 = mk(32'h200, 4'b0001, 7); s1 = mk(32'h204, 4'b0000, 0);
    disp(s0); disp(s1);
    check("ooo_pkt", execute_pkt, s1);
    sb.push_back(s1);
    alu_re = 1'b1;
    tick();
    check("ooo_occ1", occupancy, 1);
    check("ooo_not_rdy", rs_read_rdy, 0);
    cdb_ports[1] = '{is_valid: 1'b1, dest_tag: 6'd7, result: 32'hDEAD};
    tick();
    cdb_ports = '0;
    check("ooo_ignored_re", occupancy, 1);
    check("ooo_woken_rdy", rs_read_rdy, 1);
    sb.push_back(wake(s0, 0, 32'hDEAD));
    tick();
    alu_re = 1'b0;
    check("ooo_empty", occupancy, 0);
    // Capture in the dispatch cycle; port 0 beats port 1 on the same tag.
    q = mk(32'h300, 4'b1000, 3);
    cdb_ports[0] = '{is_valid: 1'b1, dest_tag: 6'd3, result: 32'h55};
    cdb_ports[1] = '{is_valid: 1'b1, dest_tag: 6'd3, result: 32'h77};
    disp(q);
    cdb_ports = '0;
    check("cap_rd_rdy", rs_read_rdy, 1);
    check("cap_pkt", execute_pkt, wake(q, 3, 32'h55));
    sb.push_back(wake(q, 3, 32'h55));
    alu_re = 1'b1;
    tick();
    alu_re = 1'b0;
    check("cap_empty", occupancy, 0);
    // Full queue, issue from slot 2, then refill at the tail.
    p0 = mk(32'h400, 4'b0001, 10); p1 = mk(32'h404, 4'b0010, 11);
    p2 = mk(32'h408, 4'b0000, 0);  p3 = mk(32'h40c, 4'b0000, 0);
    p4 = mk(32'h410, 4'b0000, 0);
    disp(p0); disp(p1); disp(p2); disp(p3);
    check("p_full_wr", rs_write_rdy, 0);
    check("p_sel_slot2", execute_pkt, p2);
    sb.push_back(p2);
    alu_re = 1'b1;
    tick();
    alu_re = 1'b0;
    check("p_occ3", occupancy, 3);
    check("p_wr_back", rs_write_rdy, 1);
    check("p_shift_pkt", execute_pkt, p3);
    disp(p4);
    check("p_refill_occ", occupancy, 4);
    sb.push_back(p3); sb.push_back(p4);
    alu_re = 1'b1;
    tick(); tick();
    check("p_occ2", occupancy, 2);
    check("p_none_rdy", rs_read_rdy, 0);
    cdb_ports[0] = '{is_valid: 1'b1, dest_tag: 6'd11, result: 32'h1111};
    cdb_ports[1] = '{is_valid: 1'b1, dest_tag: 6'd10, result: 32'hDEAD};
    tick();
    cdb_ports = '0;
    check("p_woken_occ", occupancy, 2);
    sb.push_back(wake(p0, 0, 32'hDEAD)); sb.push_back(wake(p1, 1, 32'h1111));
    tick(); tick();
    alu_re = 1'b0;
    check("p_empty", occupancy, 0);
    // Issue, allocate and wakeup of a shifting slot in one cycle.
    r0 = mk(32'h500, 4'b0000, 0); r1 = mk(32'h504, 4'b0001, 20); r2 = mk(32'h508, 4'b0000, 0);
    disp(r0); disp(r1);
    sb.push_back(r0);
    alu_re = 1'b1;
    cdb_ports[0] = '{is_valid: 1'b1, dest_tag: 6'd20, result: 32'hBEEF};
    disp(r2);
    cdb_ports = '0;
    alu_re = 1'b0;
    check("ia_occ", occupancy, 2);
    check("ia_shift_wake", execute_pkt, wake(r1, 0, 32'hBEEF));
    sb.push_back(wake(r1, 0, 32'hBEEF)); sb.push_back(r2);
    alu_re = 1'b1;
    tick(); tick();
    alu_re = 1'b0;
    check("ia_empty", occupancy, 0);
    // Flush with three entries and a concurrent allocate.
    disp(a); disp(b); disp(c);
    check("fl_pre_occ", occupancy, 3);
    flush = 1'b1;
    disp(d);
    flush = 1'b0;
    check("fl_occ", occupancy, 0);
    check("fl_rd", rs_read_rdy, 0);
    check("fl_pkt", execute_pkt, 0);
    check("fl_wr", rs_write_rdy, 1);
    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
